// File: rtl/mbldcm_umul.sv
`default_nettype none
// ============================================================================
// Module   : mbldcm_umul
// Purpose  : Iterative radix-2 shift-add unsigned multiplier (IDLE/RUN/DONE).
//            One multiplier bit is retired per enabled clock, LSB first.
//            Optional macro MBLDCM_UMUL_EARLY_TERM_EN ends RUN as soon as the
//            remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module mbldcm_umul #(
  parameter int pWidthMcand  = 16,
  parameter int pWidthMplier = 16
) (
  input  logic                                iClock,
  input  logic                                iReset_n,
  input  logic                                iEnable,
  input  logic                                iStart,
  input  logic [pWidthMcand-1:0]              iMcand,
  input  logic [pWidthMplier-1:0]             iMplier,
  output logic                                oBusy,
  output logic                                oValid,
  output logic [pWidthMcand+pWidthMplier-1:0] oProduct
);

  localparam int c_pw = pWidthMcand + pWidthMplier;
  localparam int c_cw = $clog2(pWidthMplier);
  localparam logic [c_cw-1:0] c_last = c_cw'(pWidthMplier - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]              r_state;
  logic [c_pw-1:0]         r_mcand;    // multiplicand pre-shifted to the current bit index
  logic [c_pw-1:0]         r_acc;
  logic [c_pw-1:0]         r_product;
  logic [pWidthMplier-1:0] r_mplier;   // multiplier bits not yet processed
  logic [c_cw-1:0]         r_count;

  logic [c_pw-1:0]         w_acc_next;
  logic [pWidthMplier-1:0] w_mplier_next;
  logic                    w_last;

  // Next accumulator / remaining multiplier and the end-of-run condition
  always_comb begin
    w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mplier_next = r_mplier >> 1;
`ifdef MBLDCM_UMUL_EARLY_TERM_EN
    w_last        = (r_count == c_last) || (w_mplier_next == '0);
`else
    w_last        = (r_count == c_last);
`endif
  end

  // Control FSM and datapath; everything frozen while iEnable is low
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state   <= c_st_idle;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
    end else if (iEnable) begin
      case (r_state)
        c_st_idle: begin
          if (iStart) begin
            r_mcand  <= {{pWidthMplier{1'b0}}, iMcand};
            r_mplier <= iMplier;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= c_st_run;
          end
        end
        c_st_run: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          r_mcand  <= r_mcand << 1;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= c_st_done;
          end
        end
        c_st_done: begin
          // Start requests are deliberately not honoured here
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign oBusy    = (r_state != c_st_idle);
  assign oValid   = (r_state == c_st_done);
  assign oProduct = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mbldcm_umul.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbldcm_umul
// Purpose  : Self-checking bench for mbldcm_umul: directed scenarios with
//            literal expectations plus randomized traffic against a
//            transaction-level model (product = a*b, fixed latency countdown).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbldcm_umul;

  localparam int MC = 16;
  localparam int MP = 16;
  localparam int PW = MC + MP;

  logic          iClock   = 1'b0;
  logic          iReset_n = 1'b0;
  logic          iEnable  = 1'b0;
  logic          iStart   = 1'b0;
  logic [MC-1:0] iMcand   = '0;
  logic [MP-1:0] iMplier  = '0;
  logic          oBusy;
  logic          oValid;
  logic [PW-1:0] oProduct;

  int vectors = 0;
  int fails   = 0;

  // Model: phase 0 idle, 1 computing, 2 result presented
  int            m_phase;
  int            m_left;
  logic [PW-1:0] m_prod;
  logic [MC-1:0] m_a;
  logic [MP-1:0] m_b;

  mbldcm_umul #(.pWidthMcand(MC), .pWidthMplier(MP)) dut (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .iEnable  (iEnable),
    .iStart   (iStart),
    .iMcand   (iMcand),
    .iMplier  (iMplier),
    .oBusy    (oBusy),
    .oValid   (oValid),
    .oProduct (oProduct)
  );

  always #5 iClock = ~iClock;

  function automatic int exp_lat(input logic [MP-1:0] b);
`ifdef MBLDCM_UMUL_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < MP; i++) if (b[i]) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return MP;
`endif
  endfunction

  function automatic int pick_lat(input int full_lat, input int early_lat);
`ifdef MBLDCM_UMUL_EARLY_TERM_EN
    return early_lat;
`else
    return full_lat;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_prod  = '0;
  endtask

  task automatic model_step();
    logic [PW-1:0] ea, eb;
    if (!iEnable) return;
    case (m_phase)
      0: if (iStart) begin
           m_a     = iMcand;
           m_b     = iMplier;
           m_left  = exp_lat(iMplier);
           m_phase = 1;
         end
      1: begin
           m_left--;
           if (m_left == 0) begin
             ea      = PW'(m_a);
             eb      = PW'(m_b);
             m_prod  = ea * eb;
             m_phase = 2;
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_model();
    chk("busy",    64'(oBusy),    64'(m_phase != 0));
    chk("valid",   64'(oValid),   64'(m_phase == 2));
    chk("product", 64'(oProduct), 64'(m_prod));
  endtask

  // One clock: drive after negedge, model advances at posedge, check at negedge
  task automatic tick(input logic en, input logic st, input logic [MC-1:0] a, input logic [MP-1:0] b);
    iEnable = en;
    iStart  = st;
    iMcand  = a;
    iMplier = b;
    @(posedge iClock);
    if (iReset_n) model_step();
    @(negedge iClock);
    compare_model();
  endtask

  task automatic rnd_tick(input logic en, input logic st);
    logic [31:0] r;
    r = $urandom;
    tick(en, st, r[MC-1:0], r[31:32-MP]);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge
  task automatic do_reset();
    #2 iReset_n = 1'b0;
    #1;
    model_reset();
    chk("reset_busy",    64'(oBusy),    64'd0);
    chk("reset_valid",   64'(oValid),   64'd0);
    chk("reset_product", 64'(oProduct), 64'd0);
    @(negedge iClock);
    iReset_n = 1'b1;
    compare_model();
  endtask

  task automatic run_op(input string name, input logic [MC-1:0] a, input logic [MP-1:0] b,
                        input logic [PW-1:0] exp_prod, input int exp_latency);
    int n;
    tick(1'b1, 1'b1, a, b);
    chk({name, "_busy_accept"}, 64'(oBusy), 64'd1);
    n = 0;
    while (!oValid && n < 100) begin
      rnd_tick(1'b1, 1'b0);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(exp_latency));
    chk({name, "_product"}, 64'(oProduct), 64'(exp_prod));
    rnd_tick(1'b1, 1'b0);
    chk({name, "_valid_drop"}, 64'(oValid), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    logic [MC-1:0] ra;
    logic [MP-1:0] rb;

    model_reset();
    @(negedge iClock);
    chk("por_busy",    64'(oBusy),    64'd0);
    chk("por_valid",   64'(oValid),   64'd0);
    chk("por_product", 64'(oProduct), 64'd0);
    iReset_n = 1'b1;

    run_op("m1234x5678", 16'd1234,  16'd5678,  32'd7006652,   pick_lat(16, 13));
    run_op("ones",       16'hFFFF,  16'hFFFF,  32'hFFFE0001,  pick_lat(16, 16));
    run_op("zero_mcand", 16'd0,     16'hFFFF,  32'd0,         pick_lat(16, 16));
    run_op("m100x5",     16'd100,   16'd5,     32'd500,       pick_lat(16, 3));
    run_op("m7x0",       16'd7,     16'd0,     32'd0,         pick_lat(16, 1));

    // Start requests during RUN and DONE must be ignored
    tick(1'b1, 1'b1, 16'd10, 16'd20);
    n = 0;
    while (!oValid && n < 100) begin
      tick(1'b1, 1'b1, 16'd55 + 16'(n), 16'd66);
      n++;
    end
    chk("ignore_latency", 64'(n), 64'(pick_lat(16, 5)));
    chk("ignore_product", 64'(oProduct), 64'd200);
    tick(1'b1, 1'b1, 16'd77, 16'd88);
    chk("ignore_done_busy", 64'(oBusy), 64'd0);
    rnd_tick(1'b0, 1'b0);
    chk("ignore_no_second_valid", 64'(oValid), 64'd0);

    // Stalls: 3 cycles in RUN, 2 in DONE
    tick(1'b1, 1'b1, 16'd300, 16'h8001);
    rnd_tick(1'b1, 1'b0);
    rnd_tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) rnd_tick(1'b0, 1'b1);
    n = 5;
    while (!oValid && n < 100) begin
      rnd_tick(1'b1, 1'b0);
      n++;
    end
    chk("stall_cycles", 64'(n), 64'd19);
    chk("stall_product", 64'(oProduct), 64'd9830700);
    for (int i = 0; i < 2; i++) begin
      rnd_tick(1'b0, 1'b1);
      chk("stall_valid_held", 64'(oValid), 64'd1);
    end
    rnd_tick(1'b1, 1'b0);
    chk("stall_valid_drop", 64'(oValid), 64'd0);

    // Reset in the middle of RUN
    tick(1'b1, 1'b1, 16'd999, 16'd999);
    for (int i = 0; i < 4; i++) rnd_tick(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rnd_tick(1'b1, 1'b0);
      if (oValid) chk("reset_no_valid", 64'(oValid), 64'd0);
    end
    run_op("m3x4", 16'd3, 16'd4, 32'd12, pick_lat(16, 3));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = $urandom;
        case (r[1:0])
          2'd0:    ra = '1;
          2'd1:    ra = '0;
          default: ra = MC'($urandom);
        endcase
        case (r[3:2])
          2'd0:    rb = '1;
          2'd1:    rb = MP'($urandom_range(0, 7));
          default: rb = MP'($urandom);
        endcase
        tick(r[7:4] != 4'd0 && r[5:4] != 2'd0, r[9:8] == 2'd0, ra, rb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
